// File: rtl/mem_target_16b_if.sv
// rtl/mem_target_16b_if.sv - load/store bus between initiator and mem_target_16b
interface mem_target_16b_if;
    logic        mem_bus_assert;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_cmd;
    logic        be0;
    logic        be1;
    logic        t_id;
    logic        mem_rdy;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_t_id;

    modport master (
        output mem_bus_assert, mem_addr, mem_data, mem_cmd, be0, be1, t_id,
        input  mem_rdy, rd_data, rd_valid, rd_t_id
    );

    modport slave (
        input  mem_bus_assert, mem_addr, mem_data, mem_cmd, be0, be1, t_id,
        output mem_rdy, rd_data, rd_valid, rd_t_id
    );
endinterface

// File: rtl/mem_target_16b.sv
// rtl/mem_target_16b.sv - wait-stated 16-bit RAM target with byte-lane masking
module mem_target_16b #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic            clk,
    input  logic            a_rst,
    mem_target_16b_if.slave bus
);
    localparam int  DEPTH     = 1 << DEPTH_LOG2;
    localparam bit  ZERO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] cap_idx;
    logic [15:0]           cap_data;
    logic                  cap_cmd;
    logic                  cap_be0;
    logic                  cap_be1;
    logic                  cap_tid;

    logic [15:0]           mem [DEPTH];

    logic [DEPTH_LOG2-1:0] live_idx;
    logic                  unused_addr_bits;

    // Byte address to word index; upper address bits alias onto the array.
    assign live_idx         = bus.mem_addr[DEPTH_LOG2:1];
    assign unused_addr_bits = ^bus.mem_addr;

    function automatic logic [15:0] lane_mask(input logic b0, input logic b1);
        return {{8{b1}}, {8{b0}}};
    endfunction

    // Transaction sequencer; read data is sampled on the edge that enters RESP.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            cap_idx      <= '0;
            cap_data     <= 16'h0000;
            cap_cmd      <= 1'b0;
            cap_be0      <= 1'b0;
            cap_be1      <= 1'b0;
            cap_tid      <= 1'b0;
            bus.mem_rdy  <= 1'b0;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= 16'h0000;
            bus.rd_t_id  <= 1'b0;
        end else begin
            bus.mem_rdy  <= 1'b0;
            bus.rd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mem_bus_assert) begin
                        cap_idx  <= live_idx;
                        cap_data <= bus.mem_data;
                        cap_cmd  <= bus.mem_cmd;
                        cap_be0  <= bus.be0;
                        cap_be1  <= bus.be1;
                        cap_tid  <= bus.t_id;
                        cnt      <= 4'(WAIT_STATES);
                        if (ZERO_WAIT) begin
                            // No wait states: respond straight from the live request.
                            state       <= RESP;
                            bus.mem_rdy <= 1'b1;
                            bus.rd_t_id <= bus.t_id;
                            if (!bus.mem_cmd) begin
                                bus.rd_valid <= 1'b1;
                                bus.rd_data  <= mem[live_idx] & lane_mask(bus.be0, bus.be1);
                            end
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!bus.mem_bus_assert) begin
                        // Initiator withdrew: drop the transaction silently.
                        state <= IDLE;
                        cnt   <= 4'd0;
                    end else if (cnt == 4'd1) begin
                        state       <= RESP;
                        cnt         <= 4'd0;
                        bus.mem_rdy <= 1'b1;
                        bus.rd_t_id <= cap_tid;
                        if (!cap_cmd) begin
                            bus.rd_valid <= 1'b1;
                            bus.rd_data  <= mem[cap_idx] & lane_mask(cap_be0, cap_be1);
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Write commits on the RESP->IDLE edge so a following read sees it.
    always_ff @(posedge clk) begin
        if (state == RESP && cap_cmd && !a_rst) begin
            if (cap_be0) mem[cap_idx][7:0]  <= cap_data[7:0];
            if (cap_be1) mem[cap_idx][15:8] <= cap_data[15:8];
        end
    end
endmodule
